// File: rtl/placement_pkg.sv
// Shared types for the placement engine and its read-side checker: data width,
// record status codes, empty-cell marker and checker FSM encoding.
package placement_pkg;

    localparam int W = 32;

    localparam logic signed [W-1:0] EMPTY = -1;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_UNPLACED = 2'd1,
        ST_RANGE    = 2'd2,
        ST_MISMATCH = 2'd3
    } status_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_P_RD,
        S_P_WAIT,
        S_P_CHK,
        S_G_RD,
        S_G_WAIT,
        S_G_CMP,
        S_EMIT,
        S_C_RD,
        S_C_WAIT,
        S_C_CNT,
        S_FIN
    } chk_state_t;

endpackage

// File: rtl/placement_rec_reg.sv
// Record hold register: captures one (node, x, y, status) record and presents it
// on a valid/ready interface until the consumer takes it.
module placement_rec_reg
    import placement_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic                i_ready,
    input  logic signed [W-1:0] i_node,
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_y,
    input  logic [1:0]          i_status,
    output logic                o_valid,
    output logic signed [W-1:0] o_node,
    output logic signed [W-1:0] o_x,
    output logic signed [W-1:0] o_y,
    output logic [1:0]          o_status
);

    logic                r_valid;
    logic signed [W-1:0] r_node;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic [1:0]          r_status;

    // Fields only change on load, so they stay stable for as long as the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_node   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_status <= '0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_node   <= i_node;
            r_x      <= i_x;
            r_y      <= i_y;
            r_status <= i_status;
        end else if (r_valid && i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_node   = r_node;
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_status = r_status;

endmodule

// File: rtl/placement_checker.sv
// Post-placement checker: verifies every node's position and grid ownership, streams one
// record per node, then scans the grid for occupied cells no node accounts for.
module placement_checker
    import placement_pkg::*;
#(
    parameter int V        = 11,
    parameter int N        = 6,
    parameter int READ_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic signed [W-1:0] err_count,
    output logic signed [W-1:0] first_err_node,
    output logic signed [W-1:0] placed_count,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic signed [W-1:0] rec_node,
    output logic signed [W-1:0] rec_x,
    output logic signed [W-1:0] rec_y,
    output logic [1:0]          rec_status,
    output logic                pos_re,
    output logic signed [W-1:0] pos_addr,
    input  logic signed [W-1:0] pos_x_data,
    input  logic signed [W-1:0] pos_y_data,
    output logic                grid_re,
    output logic signed [W-1:0] grid_addr,
    input  logic signed [W-1:0] grid_data
);

    localparam logic signed [W-1:0] NS        = N;
    localparam logic signed [W-1:0] LAST_NODE = V - 1;
    localparam logic signed [W-1:0] LAST_CELL = N * N - 1;
    localparam logic [7:0]          WAIT_INIT = 8'((READ_LAT > 1) ? READ_LAT - 2 : 0);

    chk_state_t          r_state;
    logic [7:0]          r_wait;
    logic signed [W-1:0] r_k;
    logic signed [W-1:0] r_c;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic signed [W-1:0] r_occ;
    logic signed [W-1:0] r_err;
    logic signed [W-1:0] r_placed;
    logic signed [W-1:0] r_first;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_pos_re;
    logic                r_grid_re;
    logic signed [W-1:0] r_pos_addr;
    logic signed [W-1:0] r_grid_addr;

    logic                w_unplaced;
    logic                w_in_range;
    logic                w_load;
    status_t             w_status;
    logic signed [W-1:0] w_rec_x;
    logic signed [W-1:0] w_rec_y;
    logic                w_rec_valid;
    logic [1:0]          w_rec_status;
    logic                w_handshake;
    logic                w_ghost;

    assign w_unplaced  = (pos_x_data == EMPTY) || (pos_y_data == EMPTY);
    assign w_in_range  = (pos_x_data >= 0) && (pos_x_data < NS) &&
                         (pos_y_data >= 0) && (pos_y_data < NS);
    assign w_handshake = w_rec_valid && rec_ready;
    assign w_ghost     = (r_occ != r_placed);

    // A record is produced either straight from the position check or after the grid compare.
    always_comb begin
        w_load   = 1'b0;
        w_status = ST_OK;
        w_rec_x  = r_x;
        w_rec_y  = r_y;
        if (r_state == S_P_CHK) begin
            w_rec_x = pos_x_data;
            w_rec_y = pos_y_data;
            if (w_unplaced) begin
                w_load   = 1'b1;
                w_status = ST_UNPLACED;
            end else if (!w_in_range) begin
                w_load   = 1'b1;
                w_status = ST_RANGE;
            end
        end else if (r_state == S_G_CMP) begin
            w_load   = 1'b1;
            w_status = (grid_data == r_k) ? ST_OK : ST_MISMATCH;
        end
    end

    placement_rec_reg u_rec (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_load   (w_load),
        .i_ready  (rec_ready),
        .i_node   (r_k),
        .i_x      (w_rec_x),
        .i_y      (w_rec_y),
        .i_status (w_status),
        .o_valid  (w_rec_valid),
        .o_node   (rec_node),
        .o_x      (rec_x),
        .o_y      (rec_y),
        .o_status (w_rec_status)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_k         <= '0;
            r_c         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_occ       <= '0;
            r_err       <= '0;
            r_placed    <= '0;
            r_first     <= EMPTY;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_pos_re    <= 1'b0;
            r_grid_re   <= 1'b0;
            r_pos_addr  <= '0;
            r_grid_addr <= '0;
        end else begin
            r_pos_re  <= 1'b0;
            r_grid_re <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !r_done) begin
                        r_busy     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_err      <= '0;
                        r_placed   <= '0;
                        r_occ      <= '0;
                        r_first    <= EMPTY;
                        r_k        <= '0;
                        r_pos_re   <= 1'b1;
                        r_pos_addr <= '0;
                        r_state    <= S_P_RD;
                    end
                end
                S_P_RD: begin
                    r_wait  <= WAIT_INIT;
                    r_state <= (READ_LAT > 1) ? S_P_WAIT : S_P_CHK;
                end
                S_P_WAIT: begin
                    if (r_wait == 0) r_state <= S_P_CHK;
                    else             r_wait  <= r_wait - 8'd1;
                end
                S_P_CHK: begin
                    r_x <= pos_x_data;
                    r_y <= pos_y_data;
                    // The address is only formed once the range check passed, so it stays inside the grid.
                    if (w_unplaced || !w_in_range) begin
                        r_state <= S_EMIT;
                    end else begin
                        r_grid_re   <= 1'b1;
                        r_grid_addr <= pos_x_data * NS + pos_y_data;
                        r_state     <= S_G_RD;
                    end
                end
                S_G_RD: begin
                    r_wait  <= WAIT_INIT;
                    r_state <= (READ_LAT > 1) ? S_G_WAIT : S_G_CMP;
                end
                S_G_WAIT: begin
                    if (r_wait == 0) r_state <= S_G_CMP;
                    else             r_wait  <= r_wait - 8'd1;
                end
                S_G_CMP: begin
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        if (w_rec_status == ST_OK) begin
                            r_placed <= r_placed + 1;
                        end else begin
                            r_err <= r_err + 1;
                            if (r_err == 0) r_first <= r_k;
                        end
                        if (r_k == LAST_NODE) begin
                            r_c         <= '0;
                            r_grid_re   <= 1'b1;
                            r_grid_addr <= '0;
                            r_state     <= S_C_RD;
                        end else begin
                            r_k        <= r_k + 1;
                            r_pos_re   <= 1'b1;
                            r_pos_addr <= r_k + 1;
                            r_state    <= S_P_RD;
                        end
                    end
                end
                S_C_RD: begin
                    r_wait  <= WAIT_INIT;
                    r_state <= (READ_LAT > 1) ? S_C_WAIT : S_C_CNT;
                end
                S_C_WAIT: begin
                    if (r_wait == 0) r_state <= S_C_CNT;
                    else             r_wait  <= r_wait - 8'd1;
                end
                S_C_CNT: begin
                    if (grid_data != EMPTY) r_occ <= r_occ + 1;
                    if (r_c == LAST_CELL) begin
                        r_state <= S_FIN;
                    end else begin
                        r_c         <= r_c + 1;
                        r_grid_re   <= 1'b1;
                        r_grid_addr <= r_c + 1;
                        r_state     <= S_C_RD;
                    end
                end
                S_FIN: begin
                    // Occupied cells beyond the OK nodes mean a stale or foreign id is left in the grid.
                    if (w_ghost) r_err <= r_err + 1;
                    r_pass  <= (r_err == 0) && !w_ghost;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_node = r_first;
    assign placed_count   = r_placed;
    assign rec_valid      = w_rec_valid;
    assign rec_status     = w_rec_status;
    assign pos_re         = r_pos_re;
    assign pos_addr       = r_pos_addr;
    assign grid_re        = r_grid_re;
    assign grid_addr      = r_grid_addr;

endmodule

// File: tb/tb_placement_checker.sv
// Directed bench for placement_checker: RAM models with 2-cycle read latency, six scenarios
// covering legal placement, unplaced, out-of-range, mismatch, ghost cell, back-pressure and reset.
module tb_placement_checker;
    import placement_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                busy, done, pass;
    logic signed [31:0]  err_count, first_err_node, placed_count;
    logic                rec_valid;
    logic                rec_ready = 1'b1;
    logic signed [31:0]  rec_node, rec_x, rec_y;
    logic [1:0]          rec_status;
    logic                pos_re, grid_re;
    logic signed [31:0]  pos_addr, grid_addr;
    logic signed [31:0]  pos_x_data = 0, pos_y_data = 0, grid_data = 0;

    placement_checker #(.V(11), .N(6), .READ_LAT(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_node (first_err_node),
        .placed_count   (placed_count),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_node       (rec_node),
        .rec_x          (rec_x),
        .rec_y          (rec_y),
        .rec_status     (rec_status),
        .pos_re         (pos_re),
        .pos_addr       (pos_addr),
        .pos_x_data     (pos_x_data),
        .pos_y_data     (pos_y_data),
        .grid_re        (grid_re),
        .grid_addr      (grid_addr),
        .grid_data      (grid_data)
    );

    always #5 clk = ~clk;

    // Memory images; base layout puts node k at (bx[k], by[k]) and id k in that cell.
    logic signed [31:0] mx [0:10];
    logic signed [31:0] my [0:10];
    logic signed [31:0] mg [0:35];
    int bx [0:10] = '{0, 0, 2, 3, 4, 1, 5, 2, 3, 4, 5};
    int by [0:10] = '{0, 3, 4, 1, 5, 1, 0, 2, 5, 2, 3};
    logic [1:0] es [0:10];

    function automatic logic signed [31:0] rd_pos(input logic signed [31:0] a, input bit is_x);
        if (a >= 0 && a < 11) return is_x ? mx[a] : my[a];
        return 32'sd12345;
    endfunction

    function automatic logic signed [31:0] rd_grid(input logic signed [31:0] a);
        if (a >= 0 && a < 36) return mg[a];
        return 32'sd54321;
    endfunction

    // Two-stage read pipeline: data valid READ_LAT=2 cycles after the strobe cycle.
    logic signed [31:0] px1 = 0, py1 = 0, g1 = 0;
    always @(posedge clk) begin
        if (pos_re) begin
            px1 <= rd_pos(pos_addr, 1'b1);
            py1 <= rd_pos(pos_addr, 1'b0);
        end
        if (grid_re) g1 <= rd_grid(grid_addr);
        pos_x_data <= px1;
        pos_y_data <= py1;
        grid_data  <= g1;
    end

    // Monitor: record capture, stall stability, reads during EMIT, done and grid-read counts.
    logic signed [31:0] rn [0:127];
    logic signed [31:0] rx [0:127];
    logic signed [31:0] ry [0:127];
    logic [1:0]         rs [0:127];
    int hs = 0, done_cnt = 0, g_cnt = 0, g7_cnt = 0, stab_err = 0, stall_cnt = 0, rd_err = 0;
    logic       prev_stall = 1'b0;
    logic [97:0] sv_rec = '0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (rec_valid && rec_ready && hs < 128) begin
                rn[hs] <= rec_node;
                rx[hs] <= rec_x;
                ry[hs] <= rec_y;
                rs[hs] <= rec_status;
                hs     <= hs + 1;
            end
            if (prev_stall && (!rec_valid || {rec_node, rec_x, rec_y, rec_status} != sv_rec))
                stab_err <= stab_err + 1;
            if (rec_valid && !rec_ready) stall_cnt <= stall_cnt + 1;
            if (rec_valid && (pos_re || grid_re)) rd_err <= rd_err + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (grid_re) g_cnt <= g_cnt + 1;
            if (grid_re && pos_addr == 7) g7_cnt <= g7_cnt + 1;
            prev_stall <= rec_valid && !rec_ready;
            sv_rec     <= {rec_node, rec_x, rec_y, rec_status};
        end
    end

    // Consumer: always ready, or the repeating 0,0,1 pattern.
    int rr_mode = 0;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 1) begin
                rec_ready = (ph == 2);
                ph = (ph + 1) % 3;
            end else begin
                rec_ready = 1'b1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [127:0] obs, input logic signed [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_base();
        for (int c = 0; c < 36; c++) mg[c] = -1;
        for (int k = 0; k < 11; k++) begin
            mx[k] = bx[k];
            my[k] = by[k];
            mg[bx[k] * 6 + by[k]] = k;
            es[k] = 2'd0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_reset_state(input string p);
        check({p, "_busy"},  busy, 0);
        check({p, "_done"},  done, 0);
        check({p, "_pass"},  pass, 0);
        check({p, "_err"},   err_count, 0);
        check({p, "_first"}, first_err_node, -1);
        check({p, "_placed"}, placed_count, 0);
        check({p, "_rvalid"}, rec_valid, 0);
        check({p, "_rnode"}, rec_node, 0);
        check({p, "_rstat"}, rec_status, 0);
        check({p, "_strobes"}, {pos_re, grid_re}, 0);
    endtask

    task automatic run_test(input string p, input int e_err, input int e_first, input int e_placed,
                            input bit e_pass, input int e_gr);
        int hs0, g0;
        bit ok;
        hs0 = hs;
        g0  = g_cnt;
        pulse_start();
        @(negedge clk);
        check({p, "_busy_after_start"}, busy, 1);
        wait_done(ok);
        check({p, "_done_seen"}, ok, 1);
        check({p, "_err"},    err_count, e_err);
        check({p, "_first"},  first_err_node, e_first);
        check({p, "_placed"}, placed_count, e_placed);
        check({p, "_pass"},   pass, e_pass);
        check({p, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check({p, "_records"}, hs - hs0, 11);
        check({p, "_grid_reads"}, g_cnt - g0, e_gr);
        for (int i = 0; i < 11; i++)
            check($sformatf("%s_rec%0d", p, i),
                  {rn[hs0 + i], rx[hs0 + i], ry[hs0 + i], rs[hs0 + i]},
                  {32'(i), mx[i], my[i], es[i]});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hs0, d0, s0, st0, r0, g70;
        reset = 1'b0;
        start = 1'b1;
        load_base();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("start_during_reset_ignored", busy, 0);

        // 1: fully consistent placement; then a start coincident with done
        run_test("t1", 0, -1, 11, 1'b1, 47);
        load_base();
        pulse_start();
        wait_done(ok);
        check("t1b_done_seen", ok, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_with_done_ignored", busy, 0);
        check("pass_held_after_done", pass, 1);

        // 2: node 4 unplaced, its cell empty
        load_base();
        mx[4] = -1; my[4] = -1; mg[29] = -1; es[4] = 2'd1;
        run_test("t2", 1, 4, 10, 1'b0, 46);

        // 3: node 7 out of range, node 2 claims node 5's cell
        load_base();
        mx[2] = 1; my[2] = 1; mg[16] = -1; es[2] = 2'd3;
        mx[7] = 6; my[7] = 2; mg[14] = -1; es[7] = 2'd2;
        g70 = g7_cnt;
        run_test("t3", 2, 2, 9, 1'b0, 46);
        check("t3_no_grid_read_node7", g7_cnt - g70, 0);

        // 4: ghost id left in cell 35
        load_base();
        mg[35] = 9;
        run_test("t4", 1, -1, 11, 1'b0, 47);

        // 5: back-pressure 0,0,1
        load_base();
        s0 = stab_err; st0 = stall_cnt; r0 = rd_err;
        rr_mode = 1;
        run_test("t5", 0, -1, 11, 1'b1, 47);
        rr_mode = 0;
        check("t5_fields_stable", stab_err - s0, 0);
        check("t5_stalls_seen", (stall_cnt - st0) > 0, 1);
        check("t5_no_reads_in_emit", rd_err - r0, 0);

        // 6: reset during the grid scan, then a clean rerun
        load_base();
        d0  = done_cnt;
        hs0 = hs;
        pulse_start();
        for (int i = 0; i < 2000 && hs < hs0 + 11; i++) @(negedge clk);
        check("t6_records_before_reset", hs - hs0, 11);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (grid_re) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_scan_started", ok, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("t6_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_done_after_abort", done_cnt - d0, 0);
        check("t6_idle_after_abort", busy, 0);
        run_test("t6_rerun", 0, -1, 11, 1'b1, 47);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
